// File: rtl/parity_frame_rx.sv
// Serial frame receiver: start(0), DATA_W data bits LSB first, parity, stop(1).
// Define PARITY_ERR_CNT_EN to add the saturating err_cnt error-frame counter.
module parity_frame_rx #(
  parameter int DATA_W     = 8,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              x,
  output logic [DATA_W-1:0] data,
  output logic              done,
  output logic              parity_err,
  output logic              frame_err
`ifdef PARITY_ERR_CNT_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);
  localparam logic ODD = (ODD_PARITY != 0);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!x) state_d = S_DATA;
      S_DATA:   if (cnt_q == LAST) state_d = S_PARITY;
      S_PARITY: state_d = S_STOP;
      S_STOP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    data_d  = data_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    case (state_q)
      S_IDLE: if (!x) begin
        cnt_d   = '0;
        shreg_d = '0;
        par_d   = 1'b0;
      end
      S_DATA: begin
        for (int i = 0; i < DATA_W; i++)
          if (cnt_q == CNT_W'(i)) shreg_d[i] = x;
        par_d = par_q ^ x;
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_PARITY: par_d = par_q ^ x;
      S_STOP: begin
        // par_q holds XOR of data and parity bits; odd parity expects it to be 1
        data_d = shreg_q;
        perr_d = par_q ^ ODD;
        ferr_d = ~x;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      data_q  <= data_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data       = data_q;
  assign done       = done_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;

`ifdef PARITY_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (done_d && (perr_d || ferr_d) && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_cnt_q <= 8'd0;
    else        err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
